// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state type and constants for the fetch controller
package fetch_pkg;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        OUT  = 2'd2
    } fetch_state_t;

    // Instructions are one 32-bit word; PC advances by this many bytes.
    localparam int INST_BYTES = 4;

    // Low address bits that must be zero in a word-aligned target.
    localparam int ALIGN_MASK = INST_BYTES - 1;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter register with increment / aligned-target next-value mux
module fetch_pc_reg #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_target,
    input  logic [DATA_WIDTH-1:0] target,
    input  logic                  load_inc,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] pc_plus4
);
    import fetch_pkg::*;

    logic [DATA_WIDTH-1:0] aligned_target;
    logic [DATA_WIDTH-1:0] pc_next;

    // Redirect targets are forced onto a word boundary; arithmetic wraps naturally.
    assign aligned_target = target & ~DATA_WIDTH'(ALIGN_MASK);
    assign pc_plus4       = pc + DATA_WIDTH'(INST_BYTES);

    // Next-PC select: a redirect always wins over sequential advance.
    always_comb begin
        pc_next = pc;
        if (load_target) begin
            pc_next = aligned_target;
        end else if (load_inc) begin
            pc_next = pc_plus4;
        end
    end

    // PC register with synchronous reset to the boot address.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_ADDR;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - single-outstanding fetch sequencer; FETCH_CTRL_PERF_EN adds fetch/stall counters
module fetch_controller #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_PC_Src,
    input  logic [DATA_WIDTH-1:0] i_Branch_Address,
    input  logic                  i_Stall,
    output logic                  o_Imem_Req,
    output logic [DATA_WIDTH-1:0] o_Imem_Addr,
    input  logic                  i_Imem_Ready,
    input  logic                  i_Imem_Valid,
    input  logic [DATA_WIDTH-1:0] i_Imem_Data,
    output logic                  o_Inst_Valid,
    output logic [DATA_WIDTH-1:0] o_Instruction,
    output logic [DATA_WIDTH-1:0] o_PC
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0]           o_Fetch_Count,
    output logic [31:0]           o_Stall_Count
`endif
);
    import fetch_pkg::*;

    fetch_state_t          state;
    logic                  discard;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic                  pc_load_inc;

    // A redirect loads the PC in every state; sequential advance only on consume.
    assign pc_load_inc = (state == OUT) && !i_Stall && !i_PC_Src;

    fetch_pc_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_ADDR (RESET_ADDR)
    ) u_pc_reg (
        .clk         (clk),
        .reset       (reset),
        .load_target (i_PC_Src),
        .target      (i_Branch_Address),
        .load_inc    (pc_load_inc),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    assign o_Imem_Addr = pc;

    // Fetch sequencer: issue, wait for response (dropping stale ones), present to decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= REQ;
            discard       <= 1'b0;
            o_Imem_Req    <= 1'b1;
            o_Inst_Valid  <= 1'b0;
            o_Instruction <= '0;
            o_PC          <= '0;
        end else begin
            case (state)
                REQ: begin
                    if (i_Imem_Ready) begin
                        state      <= WAIT;
                        o_Imem_Req <= 1'b0;
                        discard    <= i_PC_Src;
                    end
                end
                WAIT: begin
                    if (i_Imem_Valid) begin
                        if (discard || i_PC_Src) begin
                            discard    <= 1'b0;
                            state      <= REQ;
                            o_Imem_Req <= 1'b1;
                        end else begin
                            o_Instruction <= i_Imem_Data;
                            o_PC          <= pc_plus4;
                            o_Inst_Valid  <= 1'b1;
                            state         <= OUT;
                        end
                    end else if (i_PC_Src) begin
                        discard <= 1'b1;
                    end
                end
                OUT: begin
                    if (i_PC_Src || !i_Stall) begin
                        o_Inst_Valid <= 1'b0;
                        o_Imem_Req   <= 1'b1;
                        state        <= REQ;
                    end
                end
                default: begin
                    state      <= REQ;
                    o_Imem_Req <= 1'b1;
                end
            endcase
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    // Count consumed instructions and stalled presentation cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_Fetch_Count <= '0;
            o_Stall_Count <= '0;
        end else if (state == OUT) begin
            if (!i_PC_Src && !i_Stall) begin
                o_Fetch_Count <= o_Fetch_Count + 32'd1;
            end
            if (i_Stall) begin
                o_Stall_Count <= o_Stall_Count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
- Sequences the fetch datapath against an instruction memory with variable latency and a request/ready/valid handshake.
- Owns the program counter and allows one outstanding request.
- Presents each fetched instruction with its PC+4 to decode, holds it under downstream stall, and drops stale responses after a branch redirect.
- Sits between execute (redirect source), instruction memory and decode.

Parameters:
- DATA_WIDTH, 32, width of PC, address and instruction.
- RESET_ADDR, 0, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- i_PC_Src  input  1  redirect strobe; take i_Branch_Address.
- i_Branch_Address  input  DATA_WIDTH  redirect target.
- i_Stall  input  1  decode cannot accept the presented instruction.
- o_Imem_Req  output  1  fetch request valid.
- o_Imem_Addr  output  DATA_WIDTH  fetch address (PC register).
- i_Imem_Ready  input  1  memory accepts the request this cycle.
- i_Imem_Valid  input  1  response valid (one cycle per accepted request).
- i_Imem_Data  input  DATA_WIDTH  response instruction.
- o_Inst_Valid  output  1  o_Instruction/o_PC valid for decode.
- o_Instruction  output  DATA_WIDTH  registered instruction.
- o_PC  output  DATA_WIDTH  address of presented instruction + 4.

Behaviour:
- Reset: state=REQ, PC=RESET_ADDR, discard=0, o_Inst_Valid=0, o_Instruction=0, o_PC=0. o_Imem_Req is 1 in the first cycle after reset deasserts.
- Redirect targets are word-aligned: the low 2 bits of i_Branch_Address are forced to 0.
- All PC arithmetic wraps modulo 2^DATA_WIDTH.
- REQ state:
  - o_Imem_Req=1, o_Imem_Addr=PC.
  - Ready=1, no redirect: go to WAIT.
  - Ready=1 with redirect: PC<=target, discard<=1, go to WAIT.
  - Ready=0 with redirect: PC<=target, stay in REQ. The address changes next cycle; memory treats req/addr as valid only while high.
- WAIT state:
  - o_Imem_Req=0.
  - Redirect in WAIT: PC<=target, discard<=1.
  - On i_Imem_Valid with discard=1 (or redirect in the same cycle): drop the data, discard<=0, go to REQ.
  - On i_Imem_Valid otherwise: o_Instruction<=data, o_PC<=PC+4, o_Inst_Valid<=1, go to OUT.
- OUT state:
  - Outputs held stable while i_Stall=1.
  - i_Stall=0: instruction consumed this cycle. PC<=PC+4, o_Inst_Valid<=0, go to REQ.
  - Redirect (stall or not): o_Inst_Valid<=0, PC<=target, go to REQ. Redirect beats consume.
- Latency:
  - Minimum 3 cycles from request to the next request: REQ→WAIT→OUT.
  - Zero-latency memory is not supported; the response arrives at earliest the cycle after acceptance.
- i_Imem_Valid outside WAIT is ignored.
- Reset asserted mid-operation: state returns to REQ at RESET_ADDR. An in-flight response arriving after reset is ignored, because the state is not WAIT.

Optional Feature:
- Macro: FETCH_CTRL_PERF_EN.
- Defined:
  - Adds outputs o_Fetch_Count and o_Stall_Count, each 32 bits, reset to 0, wrapping.
  - o_Fetch_Count increments on each consumed instruction (OUT, i_Stall=0, no redirect).
  - o_Stall_Count increments each cycle in OUT with i_Stall=1.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg holds:
  - fetch_state_t enum {REQ, WAIT, OUT}.
  - constant INST_BYTES=4.
  - constant ALIGN_MASK.
- One natural sub-module: fetch_pc_reg. It is the PC register with synchronous reset to RESET_ADDR and load-enable, next-value mux (PC+4 / aligned target).

Test Plan:
- Reset, memory always ready with latency 1, no stall:
  - o_Imem_Addr sequence 0x0, 0x4, 0x8.
  - o_Inst_Valid every 3rd cycle with o_PC 0x4, 0x8, 0xC.
- Stall held 4 cycles in OUT: o_Instruction and o_PC unchanged throughout; next request goes to PC+4 only after i_Stall falls.
- Redirect to 0x103 during WAIT at PC=0x8: response for 0x8 dropped (o_Inst_Valid stays 0); next request at 0x100.
- Redirect to 0x200 in OUT with i_Stall=1: o_Inst_Valid drops next cycle; next request at 0x200; the held instruction is never consumed.
- i_Imem_Ready low 5 cycles with redirect to 0x40 on cycle 2: o_Imem_Addr switches to 0x40; the first accepted request is 0x40 with no discard.
- Reset asserted in WAIT, then a late i_Imem_Valid: ignored; first request 0x0. With FETCH_CTRL_PERF_EN, both counters read 0.
